// File: rtl/rr_priority_arbiter.sv
// rr_priority_arbiter: registered N-way arbiter with fixed-priority or
// round-robin selection and a bounded ownership hold time.
// The owner keeps the grant while its req stays high. If MAX_HOLD is
// non-zero and another requester is waiting, the owner is pre-empted after
// MAX_HOLD consecutive granted cycles. Ownership (OWN/IDLE) is carried by
// grant_valid itself, so there is no separate state register.
module rr_priority_arbiter #(
  parameter  int N        = 4,
  parameter  int RR_MODE  = 1,
  parameter  int MAX_HOLD = 8,
  localparam int IDXW     = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    grant,
  output logic            grant_valid,
  output logic [IDXW-1:0] grant_idx,
  output logic            hold_expired
);

  // Hold counter only needs to reach MAX_HOLD-1; it is held at 0 when unlimited.
  localparam int HCW       = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int HOLD_LAST = (MAX_HOLD > 0) ? MAX_HOLD - 1 : 0;
  localparam logic [HCW-1:0]  HOLD_LAST_C = HCW'(HOLD_LAST);
  localparam logic [IDXW-1:0] LAST_IDX    = IDXW'(N - 1);

  logic [IDXW-1:0] ptr;
  logic [HCW-1:0]  hold_cnt;

  logic            owner_req;
  logic            others_req;
  logic            expire;
  logic            rearb;
  logic [N-1:0]    cand;
  logic            win_found;
  logic [IDXW-1:0] win_idx;

  logic [N-1:0]    grant_d;
  logic            valid_d;
  logic [IDXW-1:0] idx_d;
  logic            hexp_d;
  logic [IDXW-1:0] ptr_d;
  logic [HCW-1:0]  cnt_d;

  // Decide whether to re-arbitrate this cycle and which requests may compete.
  always_comb begin
    owner_req  = |(req & grant);
    others_req = |(req & ~grant);
    expire     = (MAX_HOLD != 0) && grant_valid && owner_req &&
                 (hold_cnt == HOLD_LAST_C) && others_req;
    rearb      = !grant_valid || !owner_req || expire;
    // On hold expiry the current owner sits out this round.
    cand       = expire ? (req & ~grant) : req;
  end

  // Winner selection: highest index in fixed mode, first set bit at or above
  // the pointer (with wrap-around) in round-robin mode.
  always_comb begin : sel
    int j;
    j         = 0;
    win_found = 1'b0;
    win_idx   = '0;
    if (RR_MODE == 0) begin
      for (int i = 0; i < N; i++) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = IDXW'(i);
        end
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        j = int'(ptr) + i;
        if (j >= N) j = j - N;
        if (!win_found && cand[j]) begin
          win_found = 1'b1;
          win_idx   = IDXW'(j);
        end
      end
    end
  end

  // Next-state for grant, pointer and hold counter.
  always_comb begin
    grant_d = grant;
    valid_d = grant_valid;
    idx_d   = grant_idx;
    hexp_d  = 1'b0;
    ptr_d   = ptr;
    cnt_d   = hold_cnt;
    if (rearb) begin
      if (win_found) begin
        grant_d = {{(N-1){1'b0}}, 1'b1} << win_idx;
        valid_d = 1'b1;
        idx_d   = win_idx;
        hexp_d  = expire;
        cnt_d   = '0;
        ptr_d   = (win_idx == LAST_IDX) ? '0 : win_idx + 1'b1;
      end else begin
        grant_d = '0;
        valid_d = 1'b0;
        idx_d   = '0;
        cnt_d   = '0;
      end
    end else if (hold_cnt != HOLD_LAST_C) begin
      cnt_d = hold_cnt + 1'b1;
    end
  end

  // Registered outputs and arbitration state; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant        <= '0;
      grant_valid  <= 1'b0;
      grant_idx    <= '0;
      hold_expired <= 1'b0;
      ptr          <= '0;
      hold_cnt     <= '0;
    end else begin
      grant        <= grant_d;
      grant_valid  <= valid_d;
      grant_idx    <= idx_d;
      hold_expired <= hexp_d;
      ptr          <= ptr_d;
      hold_cnt     <= cnt_d;
    end
  end

endmodule

// File: doc/rr_priority_arbiter.md
Name: rr_priority_arbiter

Overview:
- Parametrised, registered N-way arbiter. It is the successor to the team's 4-input combinational fixed-priority arbiter.
- Supports two modes:
  - fixed priority, where the highest index wins;
  - round robin, with a rotating pointer.
- Adds grant ownership with a bounded hold time.
- Sits in front of shared resources (bus master port, memory bank) and drives one-hot grant plus encoded index to the downstream mux.

Parameters:
- N, 4, number of requesters (2..32).
- RR_MODE, 1, 0 = fixed priority (index N-1 highest, index 0 lowest); 1 = round robin.
- MAX_HOLD, 8, maximum consecutive cycles one owner keeps the grant while others are waiting; 0 = unlimited (owner keeps grant until it drops req).
- IDXW, $clog2(N), width of grant_idx (derived, not overridden).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, asynchronous active-high reset.
- req, input, N, request vector, one bit per requester, level-sensitive.
- grant, output, N, registered one-hot grant (all zero when idle).
- grant_valid, output, 1, registered; high when any grant bit is set.
- grant_idx, output, IDXW, registered binary index of the granted requester; 0 when idle.
- hold_expired, output, 1, registered one-cycle pulse when an owner is pre-empted by the MAX_HOLD limit.

Behaviour:
- Reset (async assert, sync release):
  - grant=0, grant_valid=0, grant_idx=0, hold_expired=0.
  - RR pointer=0, hold counter=0.
- Outputs are registered only. There is no combinational path from req to any output.
- Latency: a request seen at edge k is granted at edge k+1 at the earliest.
- States: IDLE (no owner) and OWN (grant_valid=1). These are encoded by grant_valid and need no separate state register.
- Arbitration is evaluated every cycle on the current req. The "rearbitrate" condition is true when any of the following holds:
  - IDLE;
  - the owner's req bit is low;
  - MAX_HOLD!=0, the hold counter is MAX_HOLD-1, and some other req bit is high.
- When rearbitrate is false: the owner is kept, grant is unchanged, and the hold counter increments (saturating at MAX_HOLD-1).
- When rearbitrate is true: a winner is selected from req. In the hold-expiry case the current owner is masked out of req before selection.
  - Fixed mode: the highest set index wins.
  - RR mode: search starts at the pointer and rises with wrap-around; the first set bit wins.
  - Winner found: grant=onehot(winner), grant_idx=winner, hold counter=0, OWN.
  - No winner: grant=0, grant_idx=0, IDLE.
- RR pointer update: on each new grant, pointer = (winner+1) mod N. The pointer is unchanged while the owner is held or the block is idle. N that is not a power of 2 must wrap correctly (e.g. N=5: 4 → 0).
- Handoff: if the owner drops req and another requester is pending, grant moves directly to the new winner on the next edge. There is no idle bubble.
- Hold expiry with no other requester pending: the owner keeps the grant, the counter stays saturated, and hold_expired stays 0.
- hold_expired=1 for exactly the one cycle after a pre-emption caused by the hold limit. It is 0 for ordinary handoffs.
- Single requester: it is granted and held indefinitely while its req stays high, regardless of MAX_HOLD.
- Simultaneous owner drop and hold expiry: treated as an ordinary drop, so hold_expired=0.
- req=0 while owning: grant deasserts on the next edge.
- Reset mid-grant: all outputs clear immediately (asynchronously). After release, the first arbitration uses pointer=0.
- Invariants (checked by assertions):
  - grant is always one-hot or zero;
  - grant_valid == |grant;
  - grant_idx matches grant;
  - grant never selects a requester whose req was low at the previous edge.

Test Plan:
1. Reset and idle: assert rst mid-operation with grant=0100 → all outputs 0 asynchronously; req=0 after release → grant stays 0000.
2. Fixed mode (RR_MODE=0, N=4): req=1011 → grant=1000, idx=3 one cycle later; drop req[3] (req=0011) → grant=0010 next cycle with no idle cycle.
3. Round robin (RR_MODE=1, N=4, MAX_HOLD=0): req=1111 with each owner releasing after 1 cycle of grant → grant sequence 0001, 0010, 0100, 1000, 0001; pointer wraps 3 → 0.
4. Hold limit (MAX_HOLD=4, RR): req=0011 held high → owner 0 for 4 cycles, then grant=0010 with hold_expired pulsed for 1 cycle, then owner 1 for 4 cycles, then back to 0001.
5. Lone requester (MAX_HOLD=4): req=0100 for 20 cycles → grant=0100 throughout; hold_expired never asserts.
6. Non-power-of-2 width (N=5, RR): req=10001, last winner 4 → next winner 0, then 4; grant_idx sequence 0, 4, 0. Random req stimulus for 10k cycles → no assertion failures and no requester waits more than (N-1)·MAX_HOLD+N cycles.
